decode_ctrl_stage: RTL and testbench

- Registered main-decoder stage that sits between the IF/ID register and the ID/EX register.
- Turns the instruction opcode into datapath control signals and drives them into the execute stage with a valid bit.
- Supports stall (hold) and flush (bubble insertion on a taken branch or jump).
- Flags illegal opcodes and keeps parametrised performance counters: accepted instructions, jumps and squashed instructions. These counters replace the earlier ad-hoc counter/jump-counter pass-through.

---
 rtl/decode_ctrl_if.sv | 34 +++
 rtl/decode_ctrl_stage.sv | 121 ++++++++++++
 tb/tb_decode_ctrl_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_if.sv
// Bundle between the IF/ID register and the decode stage: upstream opcode and
// hazard controls going in, registered control word going out to execute.
interface decode_ctrl_if #(
  parameter int OPW = 6
);
  logic           in_valid;
  logic [OPW-1:0] opcode;
  logic           stall;
  logic           flush;

  logic           out_valid;
  logic           reg_dst;
  logic           branch;
  logic           mem_read;
  logic           mem_to_reg;
  logic           mem_write;
  logic           alu_src;
  logic           reg_write;
  logic           jump;
  logic [1:0]     alu_op;
  logic           illegal;

  modport master (
    output in_valid, opcode, stall, flush,
    input  out_valid, reg_dst, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, jump, alu_op, illegal
  );

  modport slave (
    input  in_valid, opcode, stall, flush,
    output out_valid, reg_dst, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, jump, alu_op, illegal
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered main decoder: opcode -> control word into ID/EX, with stall/flush
// handling, illegal-opcode flag and performance counters.
module decode_ctrl_stage #(
  parameter int OPW = 6,
  parameter int CW  = 32,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  decode_ctrl_if.slave  bus,
  input  logic          cnt_clr,
  output logic [CW-1:0] instr_count,
  output logic [CW-1:0] jump_count,
  output logic [CW-1:0] squash_count
);

  // Control word bit order: reg_dst, branch, mem_read, mem_to_reg,
  // mem_write, alu_src, reg_write, jump, alu_op[1:0].
  localparam logic [9:0] BUBBLE = 10'b00000000_10;

  logic [9:0] dec_ctrl;
  logic       dec_legal;
  logic [9:0] ctrl_reg, ctrl_next;
  logic       valid_reg, valid_next;
  logic       illegal_reg, illegal_next;
  logic [2:0] inc;

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    case (bus.opcode)
      OPW'(0):  dec_ctrl = 10'b10000010_10;
      OPW'(1):  dec_ctrl = 10'b00110110_00;
      OPW'(2):  dec_ctrl = 10'b00001100_00;
      OPW'(3):  dec_ctrl = 10'b01000000_01;
      OPW'(4):  dec_ctrl = 10'b00000110_00;
      OPW'(5):  dec_ctrl = 10'b00000001_00;
      default: begin
        dec_ctrl  = '0;
        dec_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    ctrl_next    = ctrl_reg;
    valid_next   = valid_reg;
    illegal_next = illegal_reg;
    if (bus.flush) begin
      ctrl_next    = BUBBLE;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        ctrl_next    = dec_ctrl;
        valid_next   = dec_legal;
        illegal_next = !dec_legal;
      end else begin
        ctrl_next    = BUBBLE;
        valid_next   = 1'b0;
        illegal_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg    <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
    end
  end

  // Squash counts any valid instruction hit by flush, even if stall is also up.
  always_comb begin
    inc    = '0;
    inc[0] = !bus.flush && !bus.stall && bus.in_valid && dec_legal;
    inc[1] = inc[0] && (bus.opcode == OPW'(5));
    inc[2] = bus.flush && bus.in_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (inc[gi]) begin
          if ((SAT != 0) && (&cnt_reg))
            cnt_reg <= cnt_reg;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign instr_count  = g_cnt[0].cnt_reg;
  assign jump_count   = g_cnt[1].cnt_reg;
  assign squash_count = g_cnt[2].cnt_reg;

  assign bus.reg_dst    = ctrl_reg[9];
  assign bus.branch     = ctrl_reg[8];
  assign bus.mem_read   = ctrl_reg[7];
  assign bus.mem_to_reg = ctrl_reg[6];
  assign bus.mem_write  = ctrl_reg[5];
  assign bus.alu_src    = ctrl_reg[4];
  assign bus.reg_write  = ctrl_reg[3];
  assign bus.jump       = ctrl_reg[2];
  assign bus.alu_op     = ctrl_reg[1:0];
  assign bus.out_valid  = valid_reg;
  assign bus.illegal    = illegal_reg;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed plus random checking of decode_ctrl_stage against a table-driven
// model; 4-bit counter variants cover wrap and saturate overflow.
module tb_decode_ctrl_stage;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       cnt_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // model state: expected {out_valid, illegal, control word}, raw event totals
  logic [11:0] exp_out;
  int unsigned tot_i, tot_j, tot_s;

  always #5 clk = ~clk;

  decode_ctrl_if #(.OPW(6)) b32 ();
  decode_ctrl_if #(.OPW(6)) bw4 ();
  decode_ctrl_if #(.OPW(6)) bs4 ();

  assign b32.in_valid = in_valid; assign b32.opcode = opcode;
  assign b32.stall = stall;       assign b32.flush = flush;
  assign bw4.in_valid = in_valid; assign bw4.opcode = opcode;
  assign bw4.stall = stall;       assign bw4.flush = flush;
  assign bs4.in_valid = in_valid; assign bs4.opcode = opcode;
  assign bs4.stall = stall;       assign bs4.flush = flush;

  logic [31:0] c32_i, c32_j, c32_s;
  logic [3:0]  w4_i, w4_j, w4_s, s4_i, s4_j, s4_s;

  decode_ctrl_stage #(.OPW(6), .CW(32), .SAT(0)) dut32 (
    .clk(clk), .reset(reset), .bus(b32), .cnt_clr(cnt_clr),
    .instr_count(c32_i), .jump_count(c32_j), .squash_count(c32_s));
  decode_ctrl_stage #(.OPW(6), .CW(4), .SAT(0)) dutw4 (
    .clk(clk), .reset(reset), .bus(bw4), .cnt_clr(cnt_clr),
    .instr_count(w4_i), .jump_count(w4_j), .squash_count(w4_s));
  decode_ctrl_stage #(.OPW(6), .CW(4), .SAT(1)) duts4 (
    .clk(clk), .reset(reset), .bus(bs4), .cnt_clr(cnt_clr),
    .instr_count(s4_i), .jump_count(s4_j), .squash_count(s4_s));

  logic [11:0] obs_out;
  assign obs_out = {b32.out_valid, b32.illegal, b32.reg_dst, b32.branch,
                    b32.mem_read, b32.mem_to_reg, b32.mem_write, b32.alu_src,
                    b32.reg_write, b32.jump, b32.alu_op};

  // Decode table rows: reg_dst branch mem_read mem_to_reg mem_write alu_src reg_write jump alu_op
  function automatic logic [9:0] row(input logic [5:0] op);
    case (op)
      6'd0:    return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10};
      6'd1:    return {1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00};
      6'd2:    return {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00};
      6'd3:    return {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01};
      6'd4:    return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00};
      6'd5:    return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00};
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] wrap4(input int unsigned n);
    return n % 16;
  endfunction

  function automatic logic [31:0] sat4(input int unsigned n);
    return (n > 15) ? 32'd15 : n;
  endfunction

  task automatic model_reset();
    exp_out = 12'b0;
    tot_i = 0; tot_j = 0; tot_s = 0;
  endtask

  task automatic model_edge();
    bit legal;
    legal = (opcode < 6);
    if (reset) begin
      model_reset();
      return;
    end
    if (cnt_clr) begin
      tot_i = 0; tot_j = 0; tot_s = 0;
    end else begin
      if (!flush && !stall && in_valid && legal) begin
        tot_i++;
        if (opcode == 6'd5) tot_j++;
      end
      if (flush && in_valid) tot_s++;
    end
    if (flush)
      exp_out = {2'b00, 10'b00000000_10};
    else if (!stall) begin
      if (in_valid) exp_out = {legal, !legal, row(opcode)};
      else          exp_out = {2'b00, 10'b00000000_10};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"}, {20'b0, obs_out}, {20'b0, exp_out});
    chk({tag, ".i32"}, c32_i, tot_i);
    chk({tag, ".j32"}, c32_j, tot_j);
    chk({tag, ".s32"}, c32_s, tot_s);
    chk({tag, ".iw4"}, {28'b0, w4_i}, wrap4(tot_i));
    chk({tag, ".jw4"}, {28'b0, w4_j}, wrap4(tot_j));
    chk({tag, ".sw4"}, {28'b0, w4_s}, wrap4(tot_s));
    chk({tag, ".is4"}, {28'b0, s4_i}, sat4(tot_i));
    chk({tag, ".js4"}, {28'b0, s4_j}, sat4(tot_j));
    chk({tag, ".ss4"}, {28'b0, s4_s}, sat4(tot_s));
    $display("%-10s t=%0t iv=%0b op=%0d st=%0b fl=%0b clr=%0b out=%03h i=%0d j=%0d s=%0d",
             tag, $time, in_valid, opcode, stall, flush, cnt_clr, obs_out,
             c32_i, c32_j, c32_s);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic iv, input logic [5:0] op, input logic st,
                       input logic fl, input logic clr);
    in_valid = iv; opcode = op; stall = st; flush = fl; cnt_clr = clr;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("reset");
    step("reset_hold");
    reset = 1'b0;

    // all six legal opcodes back to back
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 6'(k), 1'b0, 1'b0, 1'b0);
      step("op_seq");
    end

    // LW, then hold three cycles while SW waits, then release
    drive(1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
    step("lw");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
      step("stall");
    end
    drive(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    step("sw_rel");

    // flush beats stall, squashes the JUMP
    drive(1'b1, 6'd5, 1'b1, 1'b1, 1'b0);
    step("flush_st");

    // illegal opcode, then a legal one clears the flag
    drive(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    step("illegal");
    drive(1'b1, 6'd4, 1'b0, 1'b0, 1'b0);
    step("legal_aft");

    // clear beats a simultaneous accepted instruction
    drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b1);
    step("clr_inc");

    // 17 accepted instructions: 4-bit wrap lands on 1, saturate on 15
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 6'(k % 5), 1'b0, 1'b0, 1'b0);
      step("ovf");
    end

    // asynchronous reset between edges while ADDI is registered
    drive(1'b1, 6'd4, 1'b0, 1'b0, 1'b0);
    step("addi");
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    drive(1'b1, 6'd4, 1'b1, 1'b1, 1'b0);
    step("rst_flush");
    reset = 1'b0;
    drive(1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
    step("rst_rel");

    // random traffic
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) < 8),
            ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                        : 6'($urandom_range(0, 7)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 29) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
